// File: rtl/hazard_pkg.sv
// hazard_pkg: opcodes, forwarding selects and FSM states shared by the hazard/forwarding controller.
package hazard_pkg;
    localparam logic [2:0] OP_RTYPE = 3'd0;
    localparam logic [2:0] OP_JUMP  = 3'd2;
    localparam logic [2:0] OP_LW    = 3'd4;
    localparam logic [2:0] OP_BEQ   = 3'd6;
    localparam logic [1:0] FWD_REG   = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;
    typedef enum logic {RUN, FLUSH} hazard_state_t;
endpackage

// File: rtl/hazard_dest_sel.sv
// hazard_dest_sel: decodes a pipeline stage's destination register and whether it really writes it.
module hazard_dest_sel
    import hazard_pkg::*;
#(
    parameter int INSTR_W     = 16,
    parameter int OP_W        = 3,
    parameter int REG_W       = 3,
    parameter int ZERO_REG_HW = 0
) (
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_write,
    input  logic               i_regdst,
    output logic [REG_W-1:0]   o_dest,
    output logic               o_writer
);
    localparam int RS_LSB = INSTR_W - OP_W - REG_W;
    localparam int RT_LSB = RS_LSB - REG_W;
    localparam int RD_LSB = RT_LSB - REG_W;
    logic [OP_W-1:0]  w_op;
    logic [REG_W-1:0] w_dest;
    logic             w_unused;
    assign w_op     = i_instr[INSTR_W-1 -: OP_W];
    assign w_dest   = i_regdst ? i_instr[RD_LSB +: REG_W] : i_instr[RT_LSB +: REG_W];
    assign w_unused = ^{i_instr[RS_LSB +: REG_W], i_instr[RD_LSB-1:0]};
    assign o_dest   = w_dest;
    // Jumps carry a write enable for the link path but never target the operand registers.
    assign o_writer = i_write && (w_op != OP_W'(OP_JUMP)) && (ZERO_REG_HW == 0 || w_dest != '0);
endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: load-use / stall-only hazard detection, operand forwarding selects,
// wrong-path flush sequencing and stall statistics for the five-stage pipeline.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int INSTR_W      = 16,
    parameter int OP_W         = 3,
    parameter int REG_W        = 3,
    parameter int FORWARD_EN   = 1,
    parameter int ZERO_REG_HW  = 0,
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_STALL    = 8,
    parameter int CNT_W        = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] i_ifid_instr,
    input  logic [INSTR_W-1:0] i_idex_instr,
    input  logic [INSTR_W-1:0] i_exmem_instr,
    input  logic [INSTR_W-1:0] i_memwb_instr,
    input  logic               i_idex_write,
    input  logic               i_exmem_write,
    input  logic               i_memwb_write,
    input  logic               i_idex_regdst,
    input  logic               i_exmem_regdst,
    input  logic               i_memwb_regdst,
    input  logic               i_idex_memread,
    input  logic               i_branch_taken,
    output logic               o_pc_stall,
    output logic               o_ifid_hold,
    output logic               o_idex_bubble,
    output logic               o_ifid_flush,
    output logic [1:0]         o_fwd_a,
    output logic [1:0]         o_fwd_b,
    output logic [CNT_W-1:0]   o_stall_count,
    output logic               o_stall_timeout
);
    localparam int RS_LSB = INSTR_W - OP_W - REG_W;
    localparam int RT_LSB = RS_LSB - REG_W;
    localparam int FC_W   = FLUSH_CYCLES > 2 ? $clog2(FLUSH_CYCLES - 1) : 1;
    localparam int RL_W   = $clog2(MAX_STALL + 1);
    localparam logic [FC_W-1:0] FC_INIT = FC_W'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);
    logic [OP_W-1:0]  w_ifid_op;
    logic [REG_W-1:0] w_ifid_rs, w_ifid_rt, w_idex_rs, w_idex_rt;
    logic [REG_W-1:0] w_idex_dest, w_exmem_dest, w_memwb_dest;
    logic             w_idex_wr, w_exmem_wr, w_memwb_wr;
    logic             w_use_rt, w_idex_hit, w_exmem_hit, w_hazard, w_stall, w_fwd_off, w_unused;
    hazard_state_t    r_state, w_state_nxt;
    logic [FC_W-1:0]  r_flush_cnt, w_flush_cnt_nxt;
    logic [CNT_W-1:0] r_stall_count;
    logic [RL_W-1:0]  r_run_len;
    logic             r_stall_timeout;
    assign w_ifid_op = i_ifid_instr[INSTR_W-1 -: OP_W];
    assign w_ifid_rs = i_ifid_instr[RS_LSB +: REG_W];
    assign w_ifid_rt = i_ifid_instr[RT_LSB +: REG_W];
    assign w_idex_rs = i_idex_instr[RS_LSB +: REG_W];
    assign w_idex_rt = i_idex_instr[RT_LSB +: REG_W];
    assign w_unused  = ^{i_ifid_instr[RT_LSB-1:0], i_idex_instr[INSTR_W-1 -: OP_W], i_idex_instr[RT_LSB-1:0]};
    hazard_dest_sel #(.INSTR_W(INSTR_W), .OP_W(OP_W), .REG_W(REG_W), .ZERO_REG_HW(ZERO_REG_HW)) u_idex (
        .i_instr(i_idex_instr), .i_write(i_idex_write), .i_regdst(i_idex_regdst),
        .o_dest(w_idex_dest), .o_writer(w_idex_wr));
    hazard_dest_sel #(.INSTR_W(INSTR_W), .OP_W(OP_W), .REG_W(REG_W), .ZERO_REG_HW(ZERO_REG_HW)) u_exmem (
        .i_instr(i_exmem_instr), .i_write(i_exmem_write), .i_regdst(i_exmem_regdst),
        .o_dest(w_exmem_dest), .o_writer(w_exmem_wr));
    hazard_dest_sel #(.INSTR_W(INSTR_W), .OP_W(OP_W), .REG_W(REG_W), .ZERO_REG_HW(ZERO_REG_HW)) u_memwb (
        .i_instr(i_memwb_instr), .i_write(i_memwb_write), .i_regdst(i_memwb_regdst),
        .o_dest(w_memwb_dest), .o_writer(w_memwb_wr));
    // I-type instructions reuse rt as their destination, so only R-type and BEQ read it.
    assign w_use_rt    = (w_ifid_op == OP_W'(OP_RTYPE)) || (w_ifid_op == OP_W'(OP_BEQ));
    assign w_idex_hit  = (w_idex_dest == w_ifid_rs) || (w_use_rt && w_idex_dest == w_ifid_rt);
    assign w_exmem_hit = (w_exmem_dest == w_ifid_rs) || (w_use_rt && w_exmem_dest == w_ifid_rt);
    assign w_hazard    = (FORWARD_EN != 0) ? (w_idex_wr && i_idex_memread && w_idex_hit)
                                           : ((w_idex_wr && w_idex_hit) || (w_exmem_wr && w_exmem_hit));
    assign w_stall     = w_hazard && !i_branch_taken && r_state != FLUSH;
    assign w_fwd_off   = reset || FORWARD_EN == 0;
    assign o_pc_stall    = reset || w_stall;
    assign o_ifid_hold   = reset || w_stall;
    assign o_idex_bubble = !reset && w_stall;
    assign o_ifid_flush  = !reset && (r_state == FLUSH || i_branch_taken);
    assign o_fwd_a = w_fwd_off ? FWD_REG
                   : (w_exmem_wr && w_exmem_dest == w_idex_rs) ? FWD_EXMEM
                   : (w_memwb_wr && w_memwb_dest == w_idex_rs) ? FWD_MEMWB : FWD_REG;
    assign o_fwd_b = w_fwd_off ? FWD_REG
                   : (w_exmem_wr && w_exmem_dest == w_idex_rt) ? FWD_EXMEM
                   : (w_memwb_wr && w_memwb_dest == w_idex_rt) ? FWD_MEMWB : FWD_REG;
    assign o_stall_count   = r_stall_count;
    assign o_stall_timeout = r_stall_timeout;
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end
    // A branch arriving mid-flush restarts the flush window.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        if (r_state == RUN) begin
            if (i_branch_taken && FLUSH_CYCLES > 1) begin
                w_state_nxt     = FLUSH;
                w_flush_cnt_nxt = FC_INIT;
            end
        end else if (i_branch_taken) begin
            w_flush_cnt_nxt = FC_INIT;
        end else if (r_flush_cnt == '0) begin
            w_state_nxt = RUN;
        end else begin
            w_flush_cnt_nxt = r_flush_cnt - 1'b1;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_count   <= '0;
            r_run_len       <= '0;
            r_stall_timeout <= 1'b0;
        end else begin
            r_stall_count   <= (w_stall && r_stall_count != '1) ? r_stall_count + 1'b1 : r_stall_count;
            r_run_len       <= !w_stall ? '0 : (r_run_len == RL_W'(MAX_STALL)) ? r_run_len : r_run_len + 1'b1;
            r_stall_timeout <= r_stall_timeout || (w_stall && r_run_len >= RL_W'(MAX_STALL - 1));
        end
    end
endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised hazard and forwarding controller for the 16-bit five-stage pipeline; the successor to the single-mode stall-only controller. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It produces the PC/IFID hold, the ID/EX bubble, the wrong-path flush and the ALU operand forwarding selects. It also tracks stall statistics and a stall watchdog.

## Interface
- INSTR_W, 16, instruction width
- OP_W, 3, opcode width; opcode occupies [INSTR_W-1 -: OP_W]
- REG_W, 3, register address width; rs, rt, rd fields follow the opcode contiguously (defaults: rs [12:10], rt [9:7], rd [6:4])
- FORWARD_EN, 1, 1 = forwarding mode (stall only on load-use); 0 = stall-only mode
- ZERO_REG_HW, 0, 1 = destination register 0 never creates a hazard or forward
- FLUSH_CYCLES, 1, cycles of IFID flush per taken branch (≥1)
- MAX_STALL, 8, consecutive-stall watchdog limit
- CNT_W, 16, stall counter width
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ifid_instr, idex_instr, exmem_instr, memwb_instr  in  INSTR_W  stage instructions
- idex_write, exmem_write, memwb_write  in  1  stage writes the register file
- idex_regdst, exmem_regdst, memwb_regdst  in  1  0 = destination is rt, 1 = destination is rd
- idex_memread  in  1  ID/EX instruction is a load
- branch_taken  in  1  branch resolved taken in EX this cycle
- pc_stall  out  1  hold PC
- ifid_hold  out  1  hold IF/ID register
- idex_bubble  out  1  load NOP into ID/EX
- ifid_flush  out  1  squash IF/ID contents
- fwd_a, fwd_b  out  2  operand select for rs/rt of ID/EX: 0 regfile, 1 EX/MEM, 2 MEM/WB
- stall_count  out  CNT_W  saturating count of stalled cycles
- stall_timeout  out  1  sticky watchdog flag

## Operation
- Stage destination: rt if regdst=0, else rd.
- A stage is a "writer" when write=1 and its opcode ≠ OP_JUMP. If ZERO_REG_HW=1, the destination must also be ≠0.
- IFID sources:
  - rs always.
  - rt additionally when the opcode is OP_RTYPE or OP_BEQ.
- Hazard condition:
  - FORWARD_EN=1: the ID/EX stage is a writer, idex_memread=1, and its destination equals any IFID source.
  - FORWARD_EN=0: any IFID source equals the destination of an ID/EX writer or an EX/MEM writer. MEM/WB is never checked; the register file writes before it reads.
- Stall: pc_stall = ifid_hold = idex_bubble = hazard & ~branch_taken & (state≠FLUSH).
- Branch priority: the wrong-path instruction is discarded, so no stall is raised during a branch or flush.
- Forwarding: only when FORWARD_EN=1; otherwise fwd_a and fwd_b are 0.
  - fwd_a=1 if the EX/MEM stage is a writer and its destination equals the ID/EX rs.
  - Else fwd_a=2 if the MEM/WB stage is a writer and its destination equals the ID/EX rs.
  - Else fwd_a=0.
  - fwd_b uses the same rules with the ID/EX rt.
  - EX/MEM has priority over MEM/WB.
- FSM with states RUN and FLUSH:
  - RUN: ifid_flush = branch_taken. If branch_taken=1 and FLUSH_CYCLES>1, go to FLUSH with flush_cnt = FLUSH_CYCLES-2.
  - FLUSH: ifid_flush=1. Decrement flush_cnt; return to RUN when flush_cnt=0.
  - branch_taken arriving while in FLUSH reloads flush_cnt = FLUSH_CYCLES-2.
- stall_count: +1 on each cycle with pc_stall=1 while reset=0. Saturates at all-ones; no wrap.
- Watchdog: run_len counts consecutive stall cycles and clears on any non-stall cycle. When run_len reaches MAX_STALL, stall_timeout is set and stays set until reset.

## Timing
- All hazard, stall, flush and fwd outputs are combinational from the current stage inputs and state; they are valid in the same cycle, with zero latency.
- State, flush_cnt, stall_count, run_len and stall_timeout update on the rising edge of clock.
- While reset=1:
  - pc_stall=1, ifid_hold=1, idex_bubble=0, ifid_flush=0, fwd_a=fwd_b=0.
  - The next edge sets state=RUN, counters to 0 and stall_timeout=0.
- Reset asserted mid-FLUSH aborts the flush. Reset mid-stall clears run_len without setting the timeout.
- A load-use hazard in FORWARD_EN=1 mode stalls exactly 1 cycle: the bubble in ID/EX removes the condition.

## Structure
- Package hazard_pkg holds:
  - constants OP_RTYPE=3'd0, OP_JUMP=3'd2, OP_LW=3'd4, OP_BEQ=3'd6;
  - FWD_REG=2'd0, FWD_EXMEM=2'd1, FWD_MEMWB=2'd2;
  - the FSM state typedef (RUN, FLUSH).
- One sub-module, hazard_dest_sel, is instantiated three times. It takes a stage instruction, write and regdst, and returns the destination and the writer flag.

## Test plan
- FORWARD_EN=1, ID/EX is a load to r3 (rt, regdst=0), IFID is R-type reading rs=r3 -> pc_stall=ifid_hold=idex_bubble=1 for exactly 1 cycle; stall_count=1.
- FORWARD_EN=1, EX/MEM writes r2 and MEM/WB writes r2, ID/EX rs=r2 and rt=r5, MEM/WB also writes r5 -> fwd_a=1, fwd_b=2, no stall.
- FORWARD_EN=0, EX/MEM writes r4 (rd), IFID I-type with rt field=r4 and rs=r1 -> no stall; change rs to r4 -> stall asserted.
- FLUSH_CYCLES=3, branch_taken pulses 1 cycle while a hazard is present -> ifid_flush=1 for 3 consecutive cycles, pc_stall=0 throughout.
- MAX_STALL=4, hold a FORWARD_EN=0 hazard for 6 cycles -> stall_timeout rises after the 4th stall edge and stays 1 after the hazard clears; stall_count=6.
- Assert reset in FLUSH state with stall_count=5 -> pc_stall=1 during reset; after reset ifid_flush=0, stall_count=0, stall_timeout=0.
